// File: rtl/uart_rx_monitor.sv
// 8N1 receiver on the payload ser_tx line with an RX FIFO
// behind a single-wait-state Wishbone target.
module uart_rx_monitor #(
  parameter logic [15:0] DEFAULT_DIV = 16'd15,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        rx_valid
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_e;

  state_e         state_q, state_d;
  logic           rx_m_q, rx_m_d;
  logic           rx_s_q, rx_s_d;
  logic           rx_p_q, rx_p_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [15:0]    dlat_q, dlat_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     sh_q, sh_d;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [7:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]  wp_q, wp_d;
  logic [AW-1:0]  rp_q, rp_d;
  logic [CW-1:0]  count_q, count_d;
  logic           valid_q, valid_d;
  logic           ovr_q, ovr_d;
  logic           ferr_q, ferr_d;
  logic [15:0]    div_q, div_d;
  logic           ack_q, ack_d;
  logic [31:0]    dat_q, dat_d;

  logic [15:0] d_eff;
  logic        fall, req, rd_req, wr_req;
  logic [1:0]  sel;
  logic        full, empty, pop, push;
  logic        stop_smp, ovr_set, ferr_set, clr;
  logic [31:0] rdata, status;
  logic        unused;

  assign unused = ^{wbs_sel_i, wbs_adr_i[31:4],
                    wbs_adr_i[1:0], wbs_dat_i[31:16]};

  always_comb begin
    rx_m_d = rx;
    rx_s_d = rx_m_q;
    rx_p_d = rx_s_q;
    d_eff  = (div_q < 16'd3) ? 16'd3 : div_q;
    fall   = rx_p_q & ~rx_s_q;
    req    = wbs_stb_i & wbs_cyc_i & ~ack_q;
    rd_req = req & ~wbs_we_i;
    wr_req = req & wbs_we_i;
    sel    = wbs_adr_i[3:2];
    full   = (count_q == CW'(FIFO_DEPTH));
    empty  = (count_q == '0);
    pop    = rd_req & (sel == 2'd0) & ~empty;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dlat_d   = dlat_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    stop_smp = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_START;
          cnt_d   = {1'b0, d_eff[15:1]};
          dlat_d  = d_eff;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (!rx_s_q) begin
            state_d = S_DATA;
            cnt_d   = dlat_q;
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          sh_d  = {rx_s_q, sh_q[7:1]};
          cnt_d = dlat_q;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          stop_smp = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  always_comb begin
    push     = stop_smp & rx_s_q & (~full | pop);
    ovr_set  = stop_smp & rx_s_q & full & ~pop;
    ferr_set = stop_smp & ~rx_s_q;
    mem_d    = mem_q;
    if (push) mem_d[wp_q] = sh_q;
    wp_d     = wp_q + AW'(push);
    rp_d     = rp_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    valid_d  = (count_d != '0);
    clr      = wr_req & (sel == 2'd1);
    ovr_d    = ovr_set | (ovr_q & ~(clr & wbs_dat_i[2]));
    ferr_d   = ferr_set | (ferr_q & ~(clr & wbs_dat_i[3]));
    div_d    = (wr_req && sel == 2'd2) ? wbs_dat_i[15:0] : div_q;
  end

  always_comb begin
    status = {{(32-7-CW){1'b0}}, count_q, 3'b000,
              ferr_q, ovr_q, full, valid_q};
    rdata  = '0;
    unique case (sel)
      2'd0: rdata = empty ? 32'd0 : {24'd0, mem_q[rp_q]};
      2'd1: rdata = status;
      2'd2: rdata = {16'd0, div_q};
      default: rdata = '0;
    endcase
    ack_d = req;
    dat_d = rd_req ? rdata : 32'd0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_p_q  <= 1'b1;
      cnt_q   <= '0;
      dlat_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      mem_q   <= '{default: '0};
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      div_q   <= DEFAULT_DIV;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      rx_m_q  <= rx_m_d;
      rx_s_q  <= rx_s_d;
      rx_p_q  <= rx_p_d;
      cnt_q   <= cnt_d;
      dlat_q  <= dlat_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
      div_q   <= div_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign rx_valid  = valid_q;
endmodule

// File: tb/tb_uart_rx_monitor.sv
// Bench for uart_rx_monitor: byte-level model with frame-timed
// pushes, per-cycle compare of ack/data/rx_valid, directed + random.
module tb_uart_rx_monitor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] dat;
  logic        rxv;

  uart_rx_monitor dut (
    .clock(clk), .reset(rst_n), .rx(rx),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(dat), .rx_valid(rxv)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  byte unsigned mq[$];
  logic        m_ovr = 1'b0;
  logic        m_ferr = 1'b0;
  logic [15:0] m_div = 16'd15;

  logic        req_pend = 1'b0;
  logic [31:0] req_val = '0, req_wd = '0;
  logic        req_pop = 1'b0, req_we = 1'b0;
  logic [1:0]  req_sel = '0;
  logic        exp_ack = 1'b0;
  logic [31:0] exp_dat = '0;

  function automatic logic [31:0] m_status();
    return {21'd0, 4'(mq.size()), 3'd0, m_ferr, m_ovr,
            mq.size() == 8, mq.size() != 0};
  endfunction

  function automatic int m_deff();
    return (m_div < 16'd3) ? 3 : int'(m_div);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // bus effects of a request land on the edge that samples it
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_ack  = 1'b0;
      exp_dat  = '0;
      req_pend = 1'b0;
    end else begin
      exp_ack = req_pend;
      exp_dat = req_pend ? req_val : 32'd0;
      if (req_pend) begin
        if (req_pop) void'(mq.pop_front());
        if (req_we && req_sel == 2'd1) begin
          if (req_wd[2]) m_ovr = 1'b0;
          if (req_wd[3]) m_ferr = 1'b0;
        end
        if (req_we && req_sel == 2'd2) m_div = req_wd[15:0];
      end
      req_pend = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("ack", {31'd0, ack}, {31'd0, exp_ack});
    chk("dat_o", dat, exp_dat);
    chk("rx_valid", {31'd0, rxv}, {31'd0, mq.size() != 0});
  end

  // called at posedge+2; returns at posedge+2 with ack low again
  task automatic wb(input logic w, input logic [3:0] off,
                    input logic [31:0] d, output logic [31:0] r);
    logic [31:0] ev;
    logic p;
    ev = '0;
    p  = 1'b0;
    if (!w) begin
      case (off[3:2])
        2'd0: if (mq.size() != 0) begin ev = 32'(mq[0]); p = 1'b1; end
        2'd1: ev = m_status();
        2'd2: ev = {16'd0, m_div};
        default: ev = '0;
      endcase
    end
    req_val = ev; req_pop = p; req_we = w;
    req_sel = off[3:2]; req_wd = d; req_pend = 1'b1;
    stb = 1'b1; cyc = 1'b1; we = w;
    adr = {28'd0, off}; wdat = d;
    @(posedge clk); #2;
    r = dat;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic rd(input logic [3:0] off, output logic [31:0] r);
    wb(1'b0, off, 32'd0, r);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    logic [31:0] r;
    wb(1'b1, off, d, r);
  endtask

  // stop-bit decision lands 4 + D/2 + 9*(D+1) edges after the start bit
  task automatic send_frame(input byte unsigned b, input logic stop_ok,
                            input logic upd);
    int d, p, h;
    d = m_deff();
    p = d + 1;
    h = d / 2;
    fork
      begin
        rx = 1'b0;
        repeat (p) @(posedge clk);
        #2;
        for (int i = 0; i < 8; i++) begin
          rx = b[i];
          repeat (p) @(posedge clk);
          #2;
        end
        rx = stop_ok;
        repeat (p) @(posedge clk);
        #2;
        rx = 1'b1;
        repeat (2 * p + 4) @(posedge clk);
        #2;
      end
      begin
        if (upd) begin
          repeat (4 + h + 9 * p) @(posedge clk);
          #1;
          if (stop_ok) begin
            if (mq.size() < 8) mq.push_back(b);
            else m_ovr = 1'b1;
          end else begin
            m_ferr = 1'b1;
          end
        end
      end
    join
  endtask

  logic [31:0] r;
  logic [31:0] tmp;
  int          sel_r;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    rd(4'h8, r); chk("div_reset", r, 32'h0000_000F);
    rd(4'h4, r); chk("status_reset", r, 32'h0);

    send_frame(8'hA5, 1'b1, 1'b1);
    rd(4'h4, r); chk("basic_status", r, 32'h0000_0081);
    rd(4'h0, r); chk("basic_data", r, 32'h0000_00A5);
    chk("basic_valid_drop", {31'd0, rxv}, 32'd0);
    rd(4'h0, r); chk("empty_data", r, 32'h0);

    for (int i = 1; i <= 9; i++) send_frame(byte'(i), 1'b1, 1'b1);
    rd(4'h4, r); chk("ovr_status", r, 32'h0000_0407);
    for (int i = 1; i <= 8; i++) begin
      rd(4'h0, r); chk("ovr_order", r, 32'(i));
    end
    rd(4'h4, r); chk("ovr_sticky", r, 32'h0000_0004);
    wr(4'h4, 32'h4);
    rd(4'h4, r); chk("ovr_clear", r, 32'h0);

    send_frame(8'h3C, 1'b0, 1'b1);
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #2;
    rd(4'h4, r); chk("ferr_status", r, 32'h0000_0008);
    wr(4'h4, 32'h8);
    rd(4'h4, r); chk("ferr_clear", r, 32'h0);

    fork
      send_frame(8'hC3, 1'b1, 1'b1);
      begin
        repeat (60) @(posedge clk);
        #2;
        wr(4'h8, 32'h7);
      end
    join
    rd(4'h0, r); chk("div_mid_frame", r, 32'h0000_00C3);
    send_frame(8'h5A, 1'b1, 1'b1);
    rd(4'h0, r); chk("div7_data", r, 32'h0000_005A);
    rd(4'h8, r); chk("div7_read", r, 32'h0000_0007);
    wr(4'h8, 32'hFFFF_000F);
    rd(4'h8, r); chk("div_upper_zero", r, 32'h0000_000F);

    for (int i = 1; i <= 8; i++) send_frame(byte'(8'h80 + i), 1'b1, 1'b1);
    rd(4'h4, r); chk("full_status", r, 32'h0000_0403);
    fork
      send_frame(8'h77, 1'b1, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #2;
        rd(4'h0, r); chk("pushpop_head", r, 32'h0000_0081);
      end
    join
    rd(4'h4, r); chk("pushpop_status", r, 32'h0000_0403);
    for (int i = 2; i <= 8; i++) begin
      rd(4'h0, r); chk("pushpop_order", r, 32'(8'h80 + i));
    end
    rd(4'h0, r); chk("pushpop_last", r, 32'h0000_0077);

    send_frame(8'h66, 1'b1, 1'b1);
    fork
      send_frame(8'h22, 1'b1, 1'b0);
      begin
        repeat (85) @(posedge clk);
        #2;
        rst_n = 1'b0;
        mq.delete();
        m_ovr = 1'b0; m_ferr = 1'b0; m_div = 16'd15;
        #1;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", dat, 32'd0);
        chk("rst_valid", {31'd0, rxv}, 32'd0);
      end
    join
    rst_n = 1'b1;
    @(posedge clk); #2;
    rd(4'h8, r); chk("rst_div", r, 32'h0000_000F);
    send_frame(8'h11, 1'b1, 1'b1);
    rd(4'h4, r); chk("rst_status", r, 32'h0000_0081);
    rd(4'h0, r); chk("rst_data", r, 32'h0000_0011);
    rd(4'h4, r); chk("rst_empty", r, 32'h0);

    for (int it = 0; it < 40; it++) begin
      sel_r = $urandom_range(0, 9);
      if (sel_r < 5) begin
        fork
          send_frame(byte'($urandom), $urandom_range(0, 7) != 0, 1'b1);
          begin
            if ($urandom_range(0, 1) == 1) begin
              repeat ($urandom_range(1, 120)) @(posedge clk);
              #2;
              rd(($urandom_range(0, 1) == 1) ? 4'h0 : 4'h4, tmp);
            end
          end
        join
      end else if (sel_r < 7) begin
        rd(4'h0, r);
      end else if (sel_r == 7) begin
        rd(4'h4, r);
      end else if (sel_r == 8) begin
        wr(4'h4, $urandom);
      end else begin
        tmp = $urandom;
        tmp[15:0] = 16'($urandom_range(0, 20));
        wr(4'h8, tmp);
        rd(4'h8, r);
      end
    end
    while (mq.size() != 0) rd(4'h0, r);
    rd(4'h0, r); chk("final_empty", r, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
